// File: rtl/phase_sequence_arbiter_if.sv
// Request/grant bundle between the requesting agents and the shared dig sequencer.
// master = requester side, slave = arbiter side.
interface phase_sequence_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req;
    logic            abort;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [1:0]      state;
    logic            busy;

    modport master (
        output req, abort,
        input  grant, done, state, busy
    );

    modport slave (
        input  req, abort,
        output grant, done, state, busy
    );
endinterface

// File: rtl/phase_sequence_arbiter.sv
// Round-robin arbiter that runs one requester at a time through the
// IDLE -> FALLING -> DIGGING -> DONE phase sequence with fixed dwell times.
module phase_sequence_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned FALL_CYC = 2,
    parameter int unsigned DIG_CYC  = 3,
    parameter int unsigned CW       = 4
) (
    input logic                    clk,
    input logic                    reset,
    phase_sequence_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(NREQ);

    localparam logic [1:0] StIdle    = 2'b00;
    localparam logic [1:0] StFalling = 2'b01;
    localparam logic [1:0] StDigging = 2'b10;
    localparam logic [1:0] StDone    = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   scan_idx;

    // First set request at or after ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = PW'((32'(ptr_q) + i) % NREQ);
            if (!found && bus.req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                grant_d = '0;
                if (found) begin
                    state_d          = StFalling;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = '0;
                    ptr_d            = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                end
            end
            StFalling: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(FALL_CYC - 1)) begin
                    state_d = StDigging;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDigging: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DIG_CYC - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // StDone, and recovery for anything else
                state_d = StIdle;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone) ? grant_q : '0;
endmodule

// File: tb/tb_phase_sequence_arbiter.sv
// Bench for phase_sequence_arbiter: a sequence-age reference model checked every cycle,
// directed scenarios with literal expectations, then randomized req/abort/reset traffic.
module tb_phase_sequence_arbiter;
    localparam int NREQ     = 4;
    localparam int FALL_CYC = 2;
    localparam int DIG_CYC  = 3;
    localparam int SEQ_END  = FALL_CYC + DIG_CYC;  // age of the DONE cycle

    logic clk;
    logic reset;

    phase_sequence_arbiter_if #(.NREQ(NREQ)) bus ();

    phase_sequence_arbiter #(
        .NREQ    (NREQ),
        .FALL_CYC(FALL_CYC),
        .DIG_CYC (DIG_CYC),
        .CW      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: a running sequence is just (owner, age in cycles since grant).
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    int m_w;

    always @(posedge clk) begin
        if (reset) begin
            m_owner <= -1;
            m_age   <= 0;
            m_ptr   <= 0;
        end else if (m_owner < 0) begin
            m_w = -1;
            for (int i = 0; i < NREQ; i++)
                if (m_w < 0 && bus.req[(m_ptr + i) % NREQ]) m_w = (m_ptr + i) % NREQ;
            if (m_w >= 0) begin
                m_owner <= m_w;
                m_age   <= 0;
                m_ptr   <= (m_w + 1) % NREQ;
            end
        end else if (m_age == SEQ_END || bus.abort) begin
            m_owner <= -1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    function automatic logic [31:0] exp_state();
        if (m_owner < 0) return 0;
        if (m_age < FALL_CYC) return 1;
        if (m_age < SEQ_END) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] exp_grant();
        return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_state", 32'(bus.state), exp_state());
            chk("m_grant", 32'(bus.grant), exp_grant());
            chk("m_busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
            chk("m_done", 32'(bus.done), (m_owner >= 0 && m_age == SEQ_END) ? exp_grant() : 32'd0);
        end
    end

    logic [1:0] t1_states [7];

    initial begin
        t1_states = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        reset     = 1'b1;
        bus.req   = '0;
        bus.abort = 1'b0;
        step();
        step();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Single requester, full phase timeline.
        bus.req = 4'b0001;
        for (int j = 0; j < 7; j++) begin
            step();
            chk("t1_state", 32'(bus.state), 32'(t1_states[j]));
            if (j == 0) chk("t1_grant", 32'(bus.grant), 32'h1);
            if (j == 5) chk("t1_done", 32'(bus.done), 32'h1);
        end
        bus.req = '0;

        // All requesting: rotation from ptr 0, one IDLE cycle between sequences.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int t = 0; t < 10; t++) begin
                step();
                if (bus.busy) break;
            end
            chk("t2_busy", 32'(bus.busy), 1);
            chk("t2_grant", 32'(bus.grant), 32'h1 << (s % 4));
            repeat (SEQ_END + 1) step();
            chk("t2_gap_idle", 32'(bus.state), 0);
        end
        bus.req = '0;

        // Owner 1 leaves ptr=2; req 0011 then picks requester 0. Owner drops req.
        bus.req = 4'b0010;
        step();
        chk("t3_grant1", 32'(bus.grant), 32'h2);
        bus.req = 4'b0011;
        repeat (SEQ_END + 1) step();
        chk("t3_idle", 32'(bus.state), 0);
        step();
        chk("t3_grant0", 32'(bus.grant), 32'h1);
        bus.req = '0;
        repeat (SEQ_END) step();
        chk("t6_state", 32'(bus.state), 3);
        chk("t6_done", 32'(bus.done), 32'h1);
        step();

        // Abort in the 2nd DIGGING cycle, request still pending.
        bus.req = 4'b0100;
        step();
        repeat (FALL_CYC + 1) step();
        bus.abort = 1'b1;
        step();
        chk("t4_state", 32'(bus.state), 0);
        chk("t4_grant", 32'(bus.grant), 0);
        chk("t4_done", 32'(bus.done), 0);
        bus.abort = 1'b0;
        step();
        chk("t4_regrant", 32'(bus.grant), 32'h4);
        bus.req = '0;
        repeat (SEQ_END + 1) step();

        // Reset during FALLING returns ptr to 0.
        bus.req = 4'b0110;
        step();
        chk("t5_grant", 32'(bus.grant), 32'h2);
        reset   = 1'b1;
        bus.req = '0;
        step();
        chk("t5_state", 32'(bus.state), 0);
        chk("t5_grant0", 32'(bus.grant), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        reset   = 1'b0;
        bus.req = 4'b1010;
        step();
        chk("t5_ptr0", 32'(bus.grant), 32'h2);
        bus.req = '0;
        repeat (SEQ_END + 1) step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.abort = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            step();
        end
        reset     = 1'b0;
        bus.abort = 1'b0;
        bus.req   = '0;
        repeat (10) step();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
